// File: rtl/spi_arb_if.sv
// spi_arb_if: bundles the requester-side and SPI-master-side signals of the
// SPI arbiter. The arbiter uses the master modport (it issues the SPI strobes);
// the surrounding logic/testbench uses the slave modport.
interface spi_arb_if;
  logic [4:0]  req;
  logic [79:0] req_data;
  logic [4:0]  ack;
  logic [7:0]  rd_data;
  logic        busy;
  logic        err;
  logic        spi_wrt;
  logic [15:0] spi_data;
  logic        spi_done;
  logic [15:0] spi_rdata;
  logic [2:0]  ss;

  modport master (
    input  req, req_data, spi_done, spi_rdata,
    output ack, rd_data, busy, err, spi_wrt, spi_data, ss
  );

  modport slave (
    output req, req_data, spi_done, spi_rdata,
    input  ack, rd_data, busy, err, spi_wrt, spi_data, ss
  );
endinterface

// File: rtl/spi_arb.sv
// spi_arb: round-robin arbiter/sequencer sharing one SPI master among five
// requesters (trig pot, ch1..ch3 gain pots, calibration EEPROM). Also latches
// the low byte of the last EEPROM read.
//
// Optional feature: define SPI_ARB_TIMEOUT_EN to abort a transaction that sees
// no spi_done within TIMEOUT_CYCLES cycles of WAIT (sets sticky err).
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no transaction; ss = 7; arbitrate whenever any req is high
// SEND  | spi_wrt high for this single cycle
// WAIT  | waiting for spi_done (or timeout when enabled)
// GUARD | GUARD_CYCLES idle cycles so the acked requester's drop is seen
module spi_arb #(
  parameter int unsigned GUARD_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic      clk,
  input  logic      rst_n,
  spi_arb_if.master bus
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, GUARD} state_t;

  localparam logic [2:0] SS_NONE = 3'b111;
  localparam logic [2:0] IDX_EEP = 3'd4;

  state_t      state_q, state_d;
  logic [2:0]  win_q, win_d;
  logic [2:0]  last_q, last_d;
  logic [2:0]  ss_q, ss_d;
  logic [15:0] spi_data_q, spi_data_d;
  logic        spi_wrt_q, spi_wrt_d;
  logic [4:0]  ack_q, ack_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        busy_q, busy_d;
  logic [3:0]  guard_q, guard_d;
  logic [2:0]  pick;
  logic [7:0]  unused_rdata_hi;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // Next requester after 'last' in rotation order that has req high.
  function automatic logic [2:0] rr_pick(input logic [4:0] r, input logic [2:0] last);
    logic [2:0] cand;
    logic [2:0] sel;
    logic       found;
    cand  = last;
    sel   = 3'd0;
    found = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cand = (cand == IDX_EEP) ? 3'd0 : cand + 3'd1;
      if (!found && r[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign pick            = rr_pick(bus.req, last_q);
  assign unused_rdata_hi = bus.spi_rdata[15:8];

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    last_d     = last_q;
    ss_d       = ss_q;
    spi_data_d = spi_data_q;
    spi_wrt_d  = 1'b0;
    ack_d      = 5'b00000;
    rd_data_d  = rd_data_q;
    guard_d    = guard_q;
`ifdef SPI_ARB_TIMEOUT_EN
    tmo_d      = tmo_q;
    err_d      = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          win_d      = pick;
          ss_d       = pick;
          spi_data_d = bus.req_data[{pick, 4'b0000} +: 16];
          spi_wrt_d  = 1'b1;
          state_d    = SEND;
`ifdef SPI_ARB_TIMEOUT_EN
          tmo_d      = TW'(TIMEOUT_CYCLES);
`endif
        end else begin
          ss_d = SS_NONE;
        end
      end
      SEND: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.spi_done) begin
          ack_d   = 5'b00001 << win_q;
          guard_d = 4'(GUARD_CYCLES - 1);
          state_d = GUARD;
          if (win_q == IDX_EEP) begin
            rd_data_d = bus.spi_rdata[7:0];
          end
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (tmo_q == TW'(1)) begin
          ack_d   = 5'b00001 << win_q;
          guard_d = 4'(GUARD_CYCLES - 1);
          err_d   = 1'b1;
          state_d = GUARD;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
`endif
      end
      GUARD: begin
        if (guard_q == 4'd0) begin
          last_d  = win_q;
          ss_d    = SS_NONE;
          state_d = IDLE;
        end else begin
          guard_d = guard_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        ss_d    = SS_NONE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      win_q      <= 3'd0;
      last_q     <= IDX_EEP;
      ss_q       <= SS_NONE;
      spi_data_q <= 16'h0000;
      spi_wrt_q  <= 1'b0;
      ack_q      <= 5'b00000;
      rd_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      guard_q    <= 4'd0;
`ifdef SPI_ARB_TIMEOUT_EN
      tmo_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      last_q     <= last_d;
      ss_q       <= ss_d;
      spi_data_q <= spi_data_d;
      spi_wrt_q  <= spi_wrt_d;
      ack_q      <= ack_d;
      rd_data_q  <= rd_data_d;
      busy_q     <= busy_d;
      guard_q    <= guard_d;
`ifdef SPI_ARB_TIMEOUT_EN
      tmo_q      <= tmo_d;
      err_q      <= err_d;
`endif
    end
  end

  assign bus.ss       = ss_q;
  assign bus.spi_data = spi_data_q;
  assign bus.spi_wrt  = spi_wrt_q;
  assign bus.ack      = ack_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.busy     = busy_q;
`ifdef SPI_ARB_TIMEOUT_EN
  assign bus.err      = err_q;
`else
  assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_arb.sv
// tb_spi_arb: randomized bench for spi_arb. A requester/SPI-slave model drives
// the bus on falling edges, predicts each grant from the round-robin rule and
// pushes the expected ack/rd_data/err into a scoreboard; a separate monitor pops
// and compares whenever the arbiter pulses ack.
`timescale 1ns/1ps
module tb_spi_arb;
  localparam int G = 2;
  localparam int T = 15;

  typedef struct packed {
    logic [4:0] ack;
    logic [7:0] rd;
    logic       err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  req;
  logic [79:0] req_data;
  logic        spi_done;
  logic [15:0] spi_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t sb[$];
  int   ack_log[$];
  logic [15:0] rdata_force[$];

  // model / driver state
  int         cyc = 0;
  int         ack_cyc = -100;
  int         grant_cyc = 0;
  int         mlast = 4;
  int         done_cnt = 0;
  logic       in_flight = 1'b0;
  logic       withheld_active = 1'b0;
  logic       prev_wrt = 1'b0;
  logic [7:0] rd_m = 8'h00;
  logic       err_m = 1'b0;
  logic [15:0] cur_rdata = 16'h0000;

  // controls written by the main sequence
  int         lat_fixed = 0;
  logic       withhold = 1'b0;
  logic       spurious_en = 1'b0;
  logic [4:0] drop_mask = 5'h00;
  logic [4:0] req_raise = 5'h00;
  logic [4:0] req_load = 5'h00;
  logic       req_load_en = 1'b0;

  spi_arb_if bus();
  assign bus.req       = req;
  assign bus.req_data  = req_data;
  assign bus.spi_done  = spi_done;
  assign bus.spi_rdata = spi_rdata;

  spi_arb #(.GUARD_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Round-robin rule: first requester with req high after 'last', wrapping at 5.
  function automatic int rr_model(input logic [4:0] r, input int last);
    for (int k = 1; k <= 5; k++) begin
      int c;
      c = (last + k) % 5;
      if (((r >> c) & 5'd1) != 5'd0) return c;
    end
    return -1;
  endfunction

  function automatic logic [15:0] slice_of(input logic [79:0] d, input int i);
    logic [79:0] sh;
    sh = d >> (16 * i);
    return sh[15:0];
  endfunction

  // Requesters + SPI slave + grant predictor, all acting on falling edges.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      spi_done        = 1'b0;
      done_cnt        = 0;
      in_flight       = 1'b0;
      withheld_active = 1'b0;
      prev_wrt        = 1'b0;
      mlast           = 4;
      rd_m            = 8'h00;
      err_m           = 1'b0;
      ack_cyc         = cyc - 100;
      sb.delete();
      if (req_load_en) begin
        req         = req_load;
        req_load_en = 1'b0;
      end
    end else begin
      if (bus.spi_wrt) begin
        int   w;
        logic ok;
        ok = (req != 5'h00) && !in_flight && (cyc - ack_cyc >= G + 1) && !prev_wrt;
        check("grant_allowed", 32'(ok), 32'd1);
        w = rr_model(req, mlast);
        if (w >= 0) begin
          exp_t e;
          check("grant_ss", 32'(bus.ss), w);
          check("grant_spi_data", 32'(bus.spi_data), 32'(slice_of(req_data, w)));
          check("grant_busy", 32'(bus.busy), 32'd1);
          mlast     = w;
          grant_cyc = cyc;
          cur_rdata = (rdata_force.size() > 0) ? rdata_force.pop_front() : 16'($urandom);
          if (withhold) begin
            err_m           = 1'b1;
            withheld_active = 1'b1;
          end else begin
            done_cnt = ((lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 8))) + 1;
            if (w == 4) rd_m = cur_rdata[7:0];
          end
          e.ack = 5'(1 << w);
          e.rd  = rd_m;
          e.err = err_m;
          sb.push_back(e);
          if (((drop_mask >> w) & 5'd1) != 5'd0) req = req & ~(5'(1 << w));
        end
        in_flight = 1'b1;
      end else if (!in_flight && (cyc - ack_cyc >= G + 1) && req != 5'h00) begin
        check("missed_grant", 32'(bus.spi_wrt), 32'd1);
      end else if (!in_flight && (cyc - ack_cyc >= G)) begin
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_ss", 32'(bus.ss), 32'd7);
      end
      prev_wrt = bus.spi_wrt;

      spi_done = 1'b0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin
          spi_done  = 1'b1;
          spi_rdata = cur_rdata;
        end
      end else if (!in_flight && spurious_en && $urandom_range(0, 7) == 0) begin
        spi_done  = 1'b1;
        spi_rdata = 16'($urandom);
      end

      if (bus.ack != 5'h00) begin
        if (withheld_active) begin
          check("timeout_latency", cyc - grant_cyc, T + 1);
          withheld_active = 1'b0;
        end
        in_flight = 1'b0;
        ack_cyc   = cyc;
        req       = req & ~bus.ack;
      end

      if (req_load_en) begin
        req         = req_load;
        req_load_en = 1'b0;
      end
      if (req_raise != 5'h00) begin
        logic [4:0] nw;
        nw = req_raise & ~req;
        for (int i = 0; i < 5; i++) begin
          if (nw[i]) req_data[16*i +: 16] = 16'($urandom);
        end
        req       = req | nw;
        req_raise = 5'h00;
      end
    end
  end

  // Scoreboard monitor: every ack pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.ack != 5'h00) begin
      if (sb.size() == 0) begin
        check("ack_unexpected", 32'(bus.ack), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_onehot", 32'(bus.ack), 32'(e.ack));
        check("rd_data", 32'(bus.rd_data), 32'(e.rd));
        check("err", 32'(bus.err), 32'(e.err));
        for (int i = 0; i < 5; i++) begin
          if (bus.ack[i]) ack_log.push_back(i);
        end
      end
    end
  end

  task automatic wait_quiet(input int budget);
    int n;
    n = 0;
    while (!(req == 5'h00 && req_raise == 5'h00 && !in_flight && sb.size() == 0) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("quiet_reached", 32'(n < budget), 32'd1);
    repeat (G + 2) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    req       = 5'h1F;
    req_data  = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'hA55A};
    spi_done  = 1'b0;
    spi_rdata = 16'h0000;

    // reset with all requests held
    repeat (3) @(posedge clk);
    #1;
    check("rst_ss", 32'(bus.ss), 32'd7);
    check("rst_spi_wrt", 32'(bus.spi_wrt), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_rd_data", 32'(bus.rd_data), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_spi_data", 32'(bus.spi_data), 32'd0);
    ack_log.delete();
    lat_fixed = 20;
    @(negedge clk);
    #1 rst_n = 1'b1;

    // all five served in rotation starting at 0
    wait_quiet(1500);
    check("rotation_count", ack_log.size(), 5);
    for (int i = 0; i < 5 && i < ack_log.size(); i++) check("rotation_order", ack_log[i], i);

    // EEP read byte captured, non-EEP read leaves it alone
    lat_fixed = 0;
    rdata_force.push_back(16'h00C3);
    rdata_force.push_back(16'hFFFF);
    req_raise = 5'h10;
    wait_quiet(300);
    check("eep_rd_data", 32'(bus.rd_data), 32'hC3);
    req_raise = 5'h02;
    wait_quiet(300);
    check("ch1_keeps_rd_data", 32'(bus.rd_data), 32'hC3);

    // requester 2 drops req right after grant
    ack_log.delete();
    drop_mask = 5'h04;
    req_raise = 5'h04;
    wait_quiet(300);
    drop_mask = 5'h00;
    check("drop_ack_count", ack_log.size(), 1);
    if (ack_log.size() > 0) check("drop_ack_idx", ack_log[0], 2);

`ifdef SPI_ARB_TIMEOUT_EN
    // spi_done withheld: timeout ack, sticky err, next request still served
    withhold  = 1'b1;
    req_raise = 5'h02;
    wait_quiet(300);
    withhold  = 1'b0;
    check("err_sticky", 32'(bus.err), 32'd1);
    req_raise = 5'h01;
    wait_quiet(300);
    check("err_still_set", 32'(bus.err), 32'd1);
`endif

    // randomized traffic with spurious spi_done outside WAIT
    spurious_en = 1'b1;
    for (int i = 0; i < 800; i++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 3) == 0) req_raise = req_raise | 5'($urandom_range(0, 31));
    end
    wait_quiet(1500);
    spurious_en = 1'b0;

    // reset asserted mid-WAIT
    lat_fixed = 20;
    req_raise = 5'h08;
    n = 0;
    while (!in_flight && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("mid_wait_granted", 32'(in_flight), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    ack_log.delete();
    req_load    = 5'h00;
    req_load_en = 1'b1;
    rst_n       = 1'b0;
    #1;
    check("async_rst_ss", 32'(bus.ss), 32'd7);
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("rst_no_ack", ack_log.size(), 0);
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    check("post_rst_ss", 32'(bus.ss), 32'd7);
    check("post_rst_rd_data", 32'(bus.rd_data), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
